// File: rtl/block_field_store_pkg.sv
// Shared definitions for the brick field store: default field geometry and
// the level layout codes understood by the refill sequencer.
package block_field_store_pkg;

    localparam int DEF_NUM_BLOCKS = 100;
    localparam int DEF_COLS       = 10;
    localparam int MAX_BLOCKS     = 128;
    localparam int ADDR_W         = 7;

    typedef enum logic [1:0] {
        Layout_full    = 2'd0,
        Layout_checker = 2'd1,
        Layout_rows    = 2'd2,
        Layout_pyramid = 2'd3
    } layout_e;

endpackage

// File: rtl/block_field_store_layout_pattern.sv
// Combinational layout generator: decides whether the brick at (row, col)
// starts alive for the selected layout.
module layout_pattern
    import block_field_store_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  layout_e           i_layout,
    input  logic [ADDR_W-1:0] i_row,
    input  logic [ADDR_W-1:0] i_col,
    output logic              o_alive
);

    localparam logic [ADDR_W:0] COLS_W = (ADDR_W+1)'(COLS);

    logic [ADDR_W:0] w_diag_sum;

    // col < COLS-row rewritten as col+row < COLS so nothing can underflow
    assign w_diag_sum = {1'b0, i_col} + {1'b0, i_row};

    always_comb begin
        o_alive = 1'b0;
        case (i_layout)
            Layout_full:    o_alive = 1'b1;
            Layout_checker: o_alive = ~(i_row[0] ^ i_col[0]);
            Layout_rows:    o_alive = ~i_row[0];
            Layout_pyramid: o_alive = (i_col >= i_row) && (w_diag_sum < COLS_W);
            default:        o_alive = 1'b0;
        endcase
    end

endmodule

// File: rtl/block_field_store.sv
// Alive/dead store for every brick: combinational render lookup, query-and-kill
// hits from game logic, and a one-address-per-cycle refill from a layout.
module block_field_store
    import block_field_store_pkg::*;
#(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int COLS       = DEF_COLS
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] RENDER_ADDR,
    output logic              RENDER_ALIVE,
    input  logic              HIT_REQ,
    input  logic [ADDR_W-1:0] HIT_ADDR,
    output logic              HIT_ACK,
    output logic              HIT_WAS_ALIVE,
    input  logic              LEVEL_LOAD,
    input  logic [1:0]        LEVEL_SEL,
    output logic              BUSY,
    output logic              LOAD_DONE,
    output logic [ADDR_W-1:0] ALIVE_COUNT,
    output logic              CLEARED
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_FILL   = 1'b1;
    localparam logic [ADDR_W:0]   NB_LIMIT  = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

    logic [MAX_BLOCKS-1:0] r_bits;
    logic [0:0]            r_state;
    layout_e               r_sel;
    logic [ADDR_W-1:0]     r_fill_addr;
    logic [ADDR_W-1:0]     r_row;
    logic [ADDR_W-1:0]     r_col;
    logic [ADDR_W-1:0]     r_count;
    logic                  r_hit_ack;
    logic                  r_hit_was;
    logic                  r_load_done;
    logic                  r_cleared;

    logic w_pattern_bit;
    logic w_hit_in_range;
    logic w_hit_old;
    logic w_render_in_range;

    assign w_hit_in_range    = {1'b0, HIT_ADDR} < NB_LIMIT;
    assign w_hit_old         = w_hit_in_range & r_bits[HIT_ADDR];
    assign w_render_in_range = {1'b0, RENDER_ADDR} < NB_LIMIT;

    assign RENDER_ALIVE  = w_render_in_range & r_bits[RENDER_ADDR];
    assign HIT_ACK       = r_hit_ack;
    assign HIT_WAS_ALIVE = r_hit_was;
    assign BUSY          = (r_state == ST_FILL);
    assign LOAD_DONE     = r_load_done;
    assign ALIVE_COUNT   = r_count;
    assign CLEARED       = r_cleared;

    layout_pattern #(
        .COLS (COLS)
    ) u_layout_pattern (
        .i_layout (r_sel),
        .i_row    (r_row),
        .i_col    (r_col),
        .o_alive  (w_pattern_bit)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_bits      <= '0;
            r_state     <= ST_IDLE;
            r_sel       <= Layout_full;
            r_fill_addr <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_count     <= '0;
            r_hit_ack   <= 1'b0;
            r_hit_was   <= 1'b0;
            r_load_done <= 1'b0;
            r_cleared   <= 1'b0;
        end else begin
            r_hit_ack   <= 1'b0;
            r_hit_was   <= 1'b0;
            r_load_done <= 1'b0;
            r_cleared   <= 1'b0;

            // A load always wins: it (re)starts the fill and defers any pending hit.
            if (LEVEL_LOAD) begin
                r_sel       <= layout_e'(LEVEL_SEL);
                r_state     <= ST_FILL;
                r_fill_addr <= '0;
                r_row       <= '0;
                r_col       <= '0;
                r_count     <= '0;
            end else if (r_state == ST_FILL) begin
                r_bits[r_fill_addr] <= w_pattern_bit;
                r_count             <= r_count + ADDR_W'(w_pattern_bit);
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (r_fill_addr == LAST_ADDR) begin
                    r_state     <= ST_IDLE;
                    r_load_done <= 1'b1;
                end else begin
                    r_fill_addr <= r_fill_addr + 1'b1;
                end
            end else if (HIT_REQ) begin
                r_hit_ack <= 1'b1;
                r_hit_was <= w_hit_old;
                if (w_hit_old) begin
                    r_bits[HIT_ADDR] <= 1'b0;
                    r_count          <= r_count - 1'b1;
                    r_cleared        <= (r_count == ADDR_W'(1));
                end
            end
        end
    end

endmodule
